// File: rtl/input_debouncer.sv
// Two-channel push-button debouncer: 2-flop synchronizer plus a 4-state FSM per channel.
// Optional registered edge pulses when DEBOUNCE_EDGE_EN is defined; otherwise pulse ports tie to 0.

module input_debouncer_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic lvl,
  output logic rise,
  output logic fall
);
  typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} state_t;

  // cnt counts synchronized samples already seen at the new level
  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] sync_q;
  logic       s;
  logic       lvl_q, lvl_d;

  assign s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      state_q <= STABLE_LO;
      cnt_q   <= 8'd0;
      lvl_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LO: begin
        cnt_d = 8'd0;
        if (s) begin
          if (LAST == 8'd0) state_d = STABLE_HI;
          else begin
            state_d = PEND_HI;
            cnt_d   = 8'd1;
          end
        end
      end
      PEND_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = 8'd0;
        end else if (cnt_q >= LAST) begin
          state_d = STABLE_HI;
          cnt_d   = 8'd0;
        end else cnt_d = cnt_q + 8'd1;
      end
      STABLE_HI: begin
        cnt_d = 8'd0;
        if (!s) begin
          if (LAST == 8'd0) state_d = STABLE_LO;
          else begin
            state_d = PEND_LO;
            cnt_d   = 8'd1;
          end
        end
      end
      PEND_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = 8'd0;
        end else if (cnt_q >= LAST) begin
          state_d = STABLE_LO;
          cnt_d   = 8'd0;
        end else cnt_d = cnt_q + 8'd1;
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = 8'd0;
      end
    endcase
    lvl_d = (state_d == STABLE_HI) || (state_d == PEND_LO);
  end

  assign lvl = lvl_q;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  // Pulses share the edge on which lvl_q takes its new value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= lvl_d & ~lvl_q;
      fall_q <= ~lvl_d & lvl_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif
endmodule

module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_a,
  input  logic raw_b,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0] raw, lvl, rise, fall;

  assign raw = {raw_b, raw_a};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    input_debouncer_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[g]),
      .lvl  (lvl[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

  assign a      = lvl[0];
  assign b      = lvl[1];
  assign a_rise = rise[0];
  assign a_fall = fall[0];
  assign b_rise = rise[1];
  assign b_fall = fall[1];
endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: N=4 and N=1 instances against a history-window model via a scoreboard queue.
module tb_input_debouncer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic raw_a = 1'b0, raw_b = 1'b0, r1_a = 1'b0, r1_b = 1'b0;
  logic a, b, a_rise, a_fall, b_rise, b_fall;
  logic a1, b1, a1_rise, a1_fall, b1_rise, b1_fall;

  always #5 clk = ~clk;

  input_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .raw_a(raw_a), .raw_b(raw_b), .a(a), .b(b),
    .a_rise(a_rise), .a_fall(a_fall), .b_rise(b_rise), .b_fall(b_fall));

  input_debouncer #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .raw_a(r1_a), .raw_b(r1_b), .a(a1), .b(b1),
    .a_rise(a1_rise), .a_fall(a1_fall), .b_rise(b1_rise), .b_fall(b1_fall));

`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  typedef struct packed { logic [5:0] n4; logic [5:0] n1; } exp_t;  // {a,b,ar,af,br,bf}
  exp_t sb[$];
  int n_assert = 0, n_fail = 0, edge_n = 0;

  // Model: h[0] = newest sample; level moves to v once samples h[1..n] all equal v
  logic [8:0] h4a, h4b, h1a, h1b;
  logic m4a, m4b, m1a, m1b;

  function automatic logic mdl(input logic [8:0] h, input int n, input logic cur);
    logic ones, zeros;
    ones = 1'b1; zeros = 1'b1;
    for (int i = 1; i <= n; i++) begin
      ones  = ones & h[i];
      zeros = zeros & ~h[i];
    end
    return ones ? 1'b1 : (zeros ? 1'b0 : cur);
  endfunction

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    h4a = '0; h4b = '0; h1a = '0; h1b = '0;
    m4a = 1'b0; m4b = 1'b0; m1a = 1'b0; m1b = 1'b0;
  endtask

  // Drive at negedge, model at posedge (push), compare at next negedge (pop)
  task automatic step(input logic ra, input logic rb, input logic qa, input logic qb);
    exp_t e;
    logic na, nb, oa, ob;
    raw_a = ra; raw_b = rb; r1_a = qa; r1_b = qb;
    @(posedge clk);
    edge_n++;
    if (!rst_n) begin
      model_clear();
      e = '0;
    end else begin
      na = mdl(h4a, 4, m4a); nb = mdl(h4b, 4, m4b);
      e.n4 = {na, nb, EDGE_EN & na & ~m4a, EDGE_EN & ~na & m4a,
              EDGE_EN & nb & ~m4b, EDGE_EN & ~nb & m4b};
      m4a = na; m4b = nb;
      oa = mdl(h1a, 1, m1a); ob = mdl(h1b, 1, m1b);
      e.n1 = {oa, ob, EDGE_EN & oa & ~m1a, EDGE_EN & ~oa & m1a,
              EDGE_EN & ob & ~m1b, EDGE_EN & ~ob & m1b};
      m1a = oa; m1b = ob;
      h4a = {h4a[7:0], ra}; h4b = {h4b[7:0], rb};
      h1a = {h1a[7:0], qa}; h1b = {h1b[7:0], qb};
    end
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) chk("sb_empty", 6'd1, 6'd0);
    else begin
      e = sb.pop_front();
      chk("n4_outs", {a, b, a_rise, a_fall, b_rise, b_fall}, e.n4);
      chk("n1_outs", {a1, b1, a1_rise, a1_fall, b1_rise, b1_fall}, e.n1);
    end
  endtask

  initial begin
    int k;
    logic [4:0] bounce;
    model_clear();
    // Reset held with inputs high: outputs low before any clock edge
    raw_a = 1'b1; raw_b = 1'b1; r1_a = 1'b1; r1_b = 1'b1;
    #2;
    chk("reset_async", {a, b, a_rise, a_fall, b_rise, b_fall}, 6'd0);
    chk("reset_async_n1", {a1, b1, a1_rise, a1_fall, b1_rise, b1_fall}, 6'd0);
    @(negedge clk);
    step(1, 1, 1, 1);
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    edge_n = 0;

    // Clean press on A: raw rises before edge k, a must show at edge k+5
    while (edge_n < 9) step(0, 0, 0, 0);
    k = edge_n + 1;
    while (edge_n < k + 4) step(1, 0, 0, 0);
    chk("press_pre", {5'd0, a}, 6'd0);
    step(1, 0, 0, 0);
    chk("press_a", {4'd0, a, a_rise}, {4'd0, 1'b1, EDGE_EN});
    step(1, 0, 0, 0);
    chk("press_pulse_end", {5'd0, a_rise}, 6'd0);

    // Glitch on B: 3 cycles high is rejected
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    chk("glitch_b", {4'd0, b, b_rise}, 6'd0);

    // Release A, then bounce 1,0,1,0,1 and hold
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    chk("release_a", {5'd0, a}, 6'd0);
    bounce = 5'b10101;
    for (int i = 4; i >= 0; i--) step(bounce[i], 0, 0, 0);
    k = edge_n;
    while (edge_n < k + 4) step(1, 0, 0, 0);
    chk("bounce_pre", {5'd0, a}, 6'd0);
    step(1, 0, 0, 0);
    chk("bounce_a", {4'd0, a, a_rise}, {4'd0, 1'b1, EDGE_EN});
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

    // Simultaneous opposite changes on both channels; N=1 channels toggle together
    for (int i = 0; i < 8; i++) step(0, 1, i[1], i[1]);
    chk("simul", {4'd0, a, b}, 6'd1);
    for (int i = 0; i < 6; i++) step(1, 1, i[0], i[0]);
    chk("both_hi", {4'd0, a, b}, 6'd3);

    // Reset during PEND_LO discards the fall and emits no pulse
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_async", {a, b, a_rise, a_fall, b_rise, b_fall}, 6'd0);
    @(negedge clk);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    chk("midreset_hold", {4'd0, a, a_fall}, 6'd0);

    // Reset release with raw held high debounces normally
    rst_n = 1'b0;
    step(1, 1, 1, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1, 1, 1, 1);
    chk("post_reset_hi", {4'd0, a, b}, 6'd3);

    // Random stimulus, biased toward short runs to hit glitch/accept boundaries
    for (int i = 0; i < 120; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 40; i++) begin
      logic ra, rb;
      ra = 1'($urandom_range(0, 1)); rb = 1'($urandom_range(0, 1));
      for (int j = 0; j < int'($urandom_range(1, 6)); j++) step(ra, rb, rb, ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
